serial_add_ctrl: RTL

Multi-cycle controller that performs a `4*NIBBLES`-bit add by time-multiplexing one internal 4-bit ripple-carry adder slice, one nibble per clock, LSB nibble first. It latches operands on a start request, runs a fixed-length schedule, and reports the result with a done pulse. It sits between the lab's operand source (switches or a stimulus FSM) and the result display, so wide arithmetic reuses the same 4-bit adder datapath.

---
 rtl/serial_add_ctrl_if.sv | 28 ++
 rtl/serial_add_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle for serial_add_ctrl; the sub request exists only with SERIAL_ADD_SUB_EN.
// The master drives start/operands; the slave (controller) drives status and results.
interface serial_add_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// 4*NIBBLES-bit adder reusing one 4-bit slice, LSB nibble first; optional subtract via SERIAL_ADD_SUB_EN.
// Latency NIBBLES+1 cycles start-to-done; start is only sampled in IDLE and is dropped otherwise (no queueing).
module serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_ctrl_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_q, b_q, sum_q;
  logic          cin_q, carry_q, c3_q;
  logic [IW-1:0] idx;
  logic          load, step;
  logic [3:0]    na, nb;
  logic          c_in;
  logic [4:0]    full;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        step     = 1'b1;
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Select the current nibble of each latched operand.
  always_comb begin
    na = 4'd0;
    nb = 4'd0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx == IW'(n)) begin
        na = a_q[4*n +: 4];
        nb = b_q[4*n +: 4];
      end
    end
    c_in = (idx == '0) ? cin_q : carry_q;
    full = {1'b0, na} + {1'b0, nb} + {4'd0, c_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      c3_q    <= 1'b0;
      idx     <= '0;
    end else if (load) begin
      a_q   <= bus.a;
`ifdef SERIAL_ADD_SUB_EN
      // Subtract is A + ~B + 1, so fold the inversion and forced carry in at latch time.
      b_q   <= bus.sub ? ~bus.b : bus.b;
      cin_q <= bus.sub | bus.cin;
`else
      b_q   <= bus.b;
      cin_q <= bus.cin;
`endif
      sum_q <= '0;
      idx   <= '0;
    end else if (step) begin
      for (int n = 0; n < NIBBLES; n++) begin
        if (idx == IW'(n)) sum_q[4*n +: 4] <= full[3:0];
      end
      carry_q <= full[4];
      // Carry into bit 3 recovered from the slice sum bit and its two operand bits.
      c3_q    <= full[3] ^ na[3] ^ nb[3];
      idx     <= idx + 1'b1;
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = carry_q;
  assign bus.ovf  = c3_q ^ carry_q;

endmodule
